// File: rtl/md_cart_pkg.sv
// Shared types and constants for the cartridge-slot responder.
// Holds the FSM encoding and the $A130F1 SRAM control register layout.
package md_cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRIVE,
    ST_DONE
  } state_t;

  localparam logic [6:0]  SRAM_REG_ADDR = 7'h78;
  localparam logic [15:0] OPEN_BUS      = 16'hFFFF;
  localparam int          SRAM_EN_BIT   = 0;
  localparam int          SRAM_WP_BIT   = 1;

endpackage

// File: rtl/md_sync2.sv
// Two-flop synchroniser for one asynchronous cartridge strobe.
// RST_VAL lets active-low strobes come out of reset deasserted.
module md_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic MCLK,
  input  logic ext_reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/md_cart_responder.sv
// Cartridge side of the 68k cart bus: decodes ROM, SRAM and /TIME cycles and
// serves them through a request/ack backing-memory port with a timeout.
module md_cart_responder
  import md_cart_pkg::*;
#(
  parameter int          ROM_AW      = 21,
  parameter logic [22:0] SRAM_BASE   = 23'h100000,
  parameter int          MEM_TIMEOUT = 64,
  parameter logic        M3_MODE     = 1'b0
) (
  input  logic              MCLK,
  input  logic              ext_reset,
  input  logic [22:0]       cart_address,
  input  logic              cart_ce0,
  input  logic              cart_cas0,
  input  logic              cart_lwr,
  input  logic              cart_uwr,
  input  logic              cart_time,
  input  logic [15:0]       cart_data_in,
  output logic [15:0]       cart_data,
  output logic              cart_data_en,
  output logic              M3,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              err
);

  localparam int            CW      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  // Strobe order: {time, uwr, lwr, cas0, ce0}
  logic [4:0] strobe_raw;
  logic [4:0] strobe_s;
  assign strobe_raw = {cart_time, cart_uwr, cart_lwr, cart_cas0, cart_ce0};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    md_sync2 #(.RST_VAL(1'b1)) u_sync (
      .MCLK      (MCLK),
      .ext_reset (ext_reset),
      .d         (strobe_raw[i]),
      .q         (strobe_s[i])
    );
  end

  logic s_ce0, s_cas0, s_lwr, s_uwr, s_time;
  assign {s_time, s_uwr, s_lwr, s_cas0, s_ce0} = strobe_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   data_q;
  logic          is_read_q, abort_q;
  logic          sram_en, sram_wp;

  logic rd_trig, wr_trig, wr_ok, reg_wr, timeout, abort_now;

  assign rd_trig   = !s_ce0 && !s_cas0;
  assign wr_trig   = !s_ce0 && (!s_lwr || !s_uwr);
  assign wr_ok     = (cart_address >= SRAM_BASE) && sram_en && !sram_wp;
  assign reg_wr    = !s_time && !s_lwr && (cart_address[6:0] == SRAM_REG_ADDR);
  assign timeout   = (state_q == ST_REQ) && !mem_ack && (cnt_q == TO_LAST);
  assign abort_now = abort_q || s_ce0 || s_cas0;

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    cart_data_en = 1'b0;
    cart_data    = '0;
    case (state_q)
      ST_IDLE: begin
        if (rd_trig)       state_d = ST_REQ;
        else if (wr_trig)  state_d = wr_ok ? ST_REQ : ST_DONE;
        else if (!s_time)  state_d = ST_DONE;
      end
      ST_REQ: begin
        if (mem_ack || timeout) begin
          if (!is_read_q)     state_d = ST_DONE;
          else if (abort_now) state_d = ST_IDLE;
          else                state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (s_ce0 || s_cas0) begin
          state_d = ST_IDLE;
        end else begin
          cart_data_en = 1'b1;
          cart_data    = data_q;
        end
      end
      ST_DONE: begin
        if (&strobe_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      M3        <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      sram_en   <= 1'b0;
      sram_wp   <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      is_read_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      M3 <= M3_MODE;
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          abort_q <= 1'b0;
          if (rd_trig) begin
            mem_addr  <= cart_address[ROM_AW-1:0];
            mem_we    <= 1'b0;
            mem_be    <= 2'b11;
            mem_req   <= 1'b1;
            is_read_q <= 1'b1;
          end else if (wr_trig) begin
            if (wr_ok) begin
              mem_addr  <= cart_address[ROM_AW-1:0];
              mem_we    <= 1'b1;
              mem_be    <= {~s_uwr, ~s_lwr};
              mem_wdata <= cart_data_in;
              mem_req   <= 1'b1;
              is_read_q <= 1'b0;
            end
          end else if (reg_wr) begin
            sram_en <= cart_data_in[SRAM_EN_BIT];
            sram_wp <= cart_data_in[SRAM_WP_BIT];
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + CW'(1);
          // A read whose strobes vanish still finishes the handshake.
          if (s_ce0 || s_cas0) abort_q <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            data_q  <= mem_rdata;
          end else if (timeout) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            data_q  <= OPEN_BUS;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_cart_responder.sv
// Directed bench for md_cart_responder: ROM read, SRAM enable/protect,
// timeout, aborted read and reset during a drive cycle.
module tb_md_cart_responder;

  logic        MCLK = 1'b0;
  logic        ext_reset;
  logic [22:0] cart_address;
  logic        cart_ce0, cart_cas0, cart_lwr, cart_uwr, cart_time;
  logic [15:0] cart_data_in;
  logic [15:0] cart_data;
  logic        cart_data_en;
  logic        M3;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  md_cart_responder #(.M3_MODE(1'b1)) dut (
    .MCLK         (MCLK),
    .ext_reset    (ext_reset),
    .cart_address (cart_address),
    .cart_ce0     (cart_ce0),
    .cart_cas0    (cart_cas0),
    .cart_lwr     (cart_lwr),
    .cart_uwr     (cart_uwr),
    .cart_time    (cart_time),
    .cart_data_in (cart_data_in),
    .cart_data    (cart_data),
    .cart_data_en (cart_data_en),
    .M3           (M3),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .err          (err)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nstep(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic release_all();
    cart_ce0 = 1'b1; cart_cas0 = 1'b1; cart_lwr = 1'b1;
    cart_uwr = 1'b1; cart_time = 1'b1;
    nstep(4);
  endtask

  task automatic reg_write(input logic [15:0] val);
    cart_address = 23'h509878;
    cart_data_in = val;
    cart_time = 1'b0; cart_lwr = 1'b0;
    nstep(4);
    release_all();
  endtask

  // Holds an access for n cycles and reports whether mem_req ever rose.
  task automatic watch_req(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      nstep(1);
      if (mem_req) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    logic bad;
    ext_reset = 1'b0;
    cart_address = '0; cart_data_in = '0;
    cart_ce0 = 1'b1; cart_cas0 = 1'b1; cart_lwr = 1'b1;
    cart_uwr = 1'b1; cart_time = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0;
    #1 ext_reset = 1'b1;
    #2;
    check("rst_data_en", cart_data_en, 0);
    check("rst_data", cart_data, 0);
    check("rst_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_m3", M3, 0);
    nstep(2);
    ext_reset = 1'b0;
    nstep(1);
    check("m3_after_rst", M3, 1);

    // ROM read, ack three cycles after mem_req
    cart_address = 23'h000010; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(2);
    check("rd_req_early", mem_req, 0);
    nstep(1);
    check("rd_req", mem_req, 1);
    check("rd_addr", mem_addr, 21'h000010);
    check("rd_we", mem_we, 0);
    check("rd_be", mem_be, 2'b11);
    nstep(2);
    check("rd_req_hold", mem_req, 1);
    check("rd_en_pre_ack", cart_data_en, 0);
    mem_ack = 1'b1; mem_rdata = 16'h4E71;
    nstep(1);
    mem_ack = 1'b0;
    check("rd_en", cart_data_en, 1);
    check("rd_data", cart_data, 16'h4E71);
    check("rd_req_drop", mem_req, 0);
    cart_ce0 = 1'b1; cart_cas0 = 1'b1;
    nstep(1);
    check("rd_en_hold", cart_data_en, 1);
    nstep(1);
    check("rd_en_clear", cart_data_en, 0);
    check("rd_data_clear", cart_data, 0);
    release_all();

    // SRAM write while disabled is ignored
    cart_address = 23'h100004; cart_data_in = 16'h1234;
    cart_ce0 = 1'b0; cart_lwr = 1'b0;
    watch_req(6, seen);
    check("sram_dis_noreq", seen, 0);
    release_all();

    // Enable SRAM, then a high-byte write
    reg_write(16'h0001);
    cart_address = 23'h100004; cart_data_in = 16'hAB00;
    cart_ce0 = 1'b0; cart_uwr = 1'b0;
    nstep(3);
    check("wr_req", mem_req, 1);
    check("wr_we", mem_we, 1);
    check("wr_be", mem_be, 2'b10);
    check("wr_wdata", mem_wdata, 16'hAB00);
    check("wr_addr", mem_addr, 21'h100004);
    mem_ack = 1'b1;
    nstep(1);
    mem_ack = 1'b0;
    check("wr_req_drop", mem_req, 0);
    check("wr_no_drive", cart_data_en, 0);
    release_all();

    // Write-protect blocks writes but not reads
    reg_write(16'h0003);
    cart_address = 23'h100004; cart_data_in = 16'h5555;
    cart_ce0 = 1'b0; cart_lwr = 1'b0;
    watch_req(6, seen);
    check("sram_wp_noreq", seen, 0);
    release_all();
    cart_address = 23'h100004; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(3);
    check("wp_rd_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    nstep(1);
    mem_ack = 1'b0;
    check("wp_rd_data", cart_data, 16'h5A5A);
    release_all();

    // Read with no ack: 64-cycle timeout, open-bus data
    cart_address = 23'h000020; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(3);
    check("to_req", mem_req, 1);
    nstep(63);
    check("to_req_last", mem_req, 1);
    check("to_err_pre", err, 0);
    nstep(1);
    check("to_req_drop", mem_req, 0);
    check("to_err", err, 1);
    check("to_en", cart_data_en, 1);
    check("to_data", cart_data, 16'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    nstep(1);
    mem_ack = 1'b0;
    check("to_late_ack", cart_data, 16'hFFFF);
    cart_ce0 = 1'b1; cart_cas0 = 1'b1;
    nstep(2);
    check("to_en_clear", cart_data_en, 0);
    check("to_err_sticky", err, 1);
    release_all();

    // Strobes withdrawn during REQ: handshake completes, nothing driven
    cart_address = 23'h000040; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(3);
    check("ab_req", mem_req, 1);
    nstep(1);
    cart_cas0 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nstep(1);
      if (!mem_req || cart_data_en) bad = 1'b1;
    end
    check("ab_req_held", bad, 0);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    nstep(1);
    mem_ack = 1'b0;
    check("ab_req_drop", mem_req, 0);
    check("ab_no_en", cart_data_en, 0);
    nstep(3);
    check("ab_no_en_late", cart_data_en, 0);
    release_all();
    cart_address = 23'h000050; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(3);
    check("ab_next_req", mem_req, 1);
    check("ab_next_addr", mem_addr, 21'h000050);
    mem_ack = 1'b1; mem_rdata = 16'h600D;
    nstep(1);
    mem_ack = 1'b0;
    check("ab_next_data", cart_data, 16'h600D);
    release_all();

    // Reset pulsed in DRIVE, with SRAM enabled and writable
    reg_write(16'h0001);
    cart_address = 23'h000060; cart_ce0 = 1'b0; cart_cas0 = 1'b0;
    nstep(3);
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    nstep(1);
    mem_ack = 1'b0;
    check("rs_en_pre", cart_data_en, 1);
    ext_reset = 1'b1;
    #1;
    check("rs_en", cart_data_en, 0);
    check("rs_data", cart_data, 0);
    check("rs_m3", M3, 0);
    check("rs_err", err, 0);
    cart_ce0 = 1'b1; cart_cas0 = 1'b1;
    nstep(2);
    ext_reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hBAD0;
    nstep(1);
    mem_ack = 1'b0;
    check("rs_m3_after", M3, 1);
    check("rs_stale_ack_req", mem_req, 0);
    check("rs_stale_ack_en", cart_data_en, 0);
    nstep(3);
    cart_address = 23'h100004; cart_data_in = 16'h7777;
    cart_ce0 = 1'b0; cart_lwr = 1'b0;
    watch_req(6, seen);
    check("rs_sram_en_cleared", seen, 0);
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
